// File: rtl/bounce_generator.sv
// Contact-bounce emulator: replays a clean switch level as an LFSR-timed burst
// of toggles, then forces the output to the clean level once the window expires.
module bounce_generator #(
   parameter int unsigned BOUNCE_CYCLES = 1000,
   parameter int unsigned GAP_W         = 4,
   parameter logic [15:0] SEED          = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clean,
   input  logic       en,
   output logic       noisy,
   output logic       busy,
   output logic       done,
   output logic [7:0] bounce_cnt
);

   localparam int unsigned      WIN_W    = $clog2(BOUNCE_CYCLES);
   localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(BOUNCE_CYCLES - 1);
   localparam logic [15:0]      TAPS     = 16'hB400;

   typedef enum logic [1:0] {IDLE, BOUNCE, DONE} state_t;

   state_t           state;
   logic             clean_q;
   logic [15:0]      lfsr;
   logic [WIN_W-1:0] win_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             edge_seen;
   logic             start;
   logic [7:0]       cnt_inc;

   assign edge_seen = (clean != clean_q);
   // IDLE (with en) and DONE share one entry path into BOUNCE
   assign start     = edge_seen && (((state == IDLE) && en) || (state == DONE));
   assign cnt_inc   = (bounce_cnt == 8'hFF) ? bounce_cnt : bounce_cnt + 8'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         clean_q    <= 1'b0;
         lfsr       <= SEED;
         win_cnt    <= '0;
         gap_cnt    <= '0;
         noisy      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bounce_cnt <= '0;
      end else begin
         clean_q <= clean;
         lfsr    <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : '0);
         done    <= 1'b0;
         if (start) begin
            state      <= BOUNCE;
            busy       <= 1'b1;
            noisy      <= ~noisy;
            bounce_cnt <= 8'd1;
            win_cnt    <= WIN_LOAD;
            gap_cnt    <= lfsr[GAP_W-1:0];
         end else begin
            unique case (state)
               IDLE: begin
                  noisy <= clean;
               end
               BOUNCE: begin
                  if (!edge_seen && (win_cnt == '0)) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     noisy <= clean_q;
                  end else begin
                     win_cnt <= edge_seen ? WIN_LOAD : win_cnt - 1'b1;
                     if (gap_cnt == '0) begin
                        noisy      <= ~noisy;
                        bounce_cnt <= cnt_inc;
                        gap_cnt    <= lfsr[GAP_W-1:0];
                     end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                     end
                  end
               end
               DONE: begin
                  state <= IDLE;
                  noisy <= clean;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator: reset, pass-through, single bounce,
// restart, mid-bounce reset with trace replay, and back-to-back windows.
module tb_bounce_generator;

   logic       clk;
   logic       reset;
   logic       clean;
   logic       en;
   logic       noisy;
   logic       busy;
   logic       done;
   logic [7:0] bounce_cnt;

   int checks = 0;
   int errors = 0;

   logic [15:0] ref_lfsr;
   logic        trace  [0:2047];
   logic        golden [0:2047];
   int busy_cycles, done_cnt, first_done, last_done, toggles;
   int gap_bad, pred_bad, flip_cyc, mism;
   logic b1, busy_after_flip;

   bounce_generator #(
      .BOUNCE_CYCLES(1000),
      .GAP_W        (4),
      .SEED         (16'hACE1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clean     (clean),
      .en        (en),
      .noisy     (noisy),
      .busy      (busy),
      .done      (done),
      .bounce_cnt(bounce_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference Galois LFSR x^16+x^14+x^13+x^11+1, right-shifting form
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) ref_lfsr <= 16'hACE1;
      else       ref_lfsr <= lfsr_step(ref_lfsr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clean = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   // Runs ncyc cycles from the current negedge, measuring toggles and gaps.
   task automatic watch(input int ncyc, input int flip_at, input int en_off_at,
                        input bit flip_on_done);
      logic        pn, pb;
      logic [15:0] pl;
      int          last_t, exp_gap, g;
      bit          flipped;
      pn = noisy; pb = busy; pl = ref_lfsr;
      last_t = 0; exp_gap = 0; flipped = 1'b0;
      busy_cycles = 0; done_cnt = 0; first_done = 0; last_done = 0; toggles = 0;
      gap_bad = 0; pred_bad = 0; flip_cyc = 0; b1 = 1'b0; busy_after_flip = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         trace[c] = noisy;
         if (c == 1) b1 = busy;
         if (flipped && (c == flip_cyc + 1)) busy_after_flip = busy;
         if (busy) busy_cycles++;
         if (done) begin
            done_cnt++;
            if (first_done == 0) first_done = c;
            last_done = c;
         end
         if (busy && !pb) toggles = 0;
         if (busy && (noisy != pn)) begin
            if (toggles > 0) begin
               g = c - last_t;
               if ((g < 1) || (g > 16)) gap_bad++;
               if (g != exp_gap) pred_bad++;
            end
            toggles++;
            last_t  = c;
            exp_gap = int'(pl[3:0]) + 1;
         end
         pn = noisy; pb = busy; pl = ref_lfsr;
         if (c == flip_at) clean = ~clean;
         if (c == en_off_at) en = 1'b0;
         if (flip_on_done && done && !flipped) begin
            clean    = ~clean;
            flipped  = 1'b1;
            flip_cyc = c;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      clean = 1'b0;
      en    = 1'b0;

      // Reset pulse
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_hold", {noisy, busy, done, bounce_cnt}, 11'd0);
      end
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("reset_release", {noisy, busy, done, bounce_cnt}, 11'd0);
      end

      // Pass-through, one cycle latency
      clean = 1'b1;
      chk("pass_not_early", noisy, 1'b0);
      @(negedge clk);
      chk("pass_rise", noisy, 1'b1);
      chk("pass_quiet", {busy, done, bounce_cnt}, 10'd0);
      clean = 1'b0;
      @(negedge clk);
      chk("pass_fall", noisy, 1'b0);

      // Single bounce from a known reset alignment
      do_reset();
      en    = 1'b1;
      clean = 1'b1;
      watch(1010, 0, 0, 1'b0);
      for (int c = 0; c <= 1010; c++) golden[c] = trace[c];
      chk("single_busy_next", b1, 1'b1);
      chk("single_first_toggle", trace[1], 1'b1);
      chk("single_busy_len", busy_cycles, 1000);
      chk("single_done_cnt", done_cnt, 1);
      chk("single_done_at", first_done, 1001);
      chk("single_settled", noisy, 1'b1);
      chk("single_cnt", bounce_cnt, toggles);
      chk("single_gap_range", gap_bad, 0);
      chk("single_gap_lfsr", pred_bad, 0);
      chk("single_has_toggles", (toggles >= 2), 1'b1);

      // Reset 300 cycles into the window
      do_reset();
      clean = 1'b1;
      watch(300, 0, 0, 1'b0);
      mism = 0;
      for (int c = 1; c <= 300; c++) if (trace[c] !== golden[c]) mism++;
      chk("abort_prefix_trace", mism, 0);
      chk("abort_busy_before", busy, 1'b1);
      reset = 1'b1;
      clean = 1'b0;
      #1;
      chk("abort_clear_now", {noisy, busy, done, bounce_cnt}, 11'd0);
      watch(3, 0, 0, 1'b0);
      chk("abort_no_done_in_reset", done_cnt, 0);
      reset = 1'b0;
      watch(20, 0, 0, 1'b0);
      chk("abort_no_done_after", done_cnt, 0);
      chk("abort_idle_after", busy_cycles, 0);

      // Replay must be bit-identical
      do_reset();
      clean = 1'b1;
      watch(1010, 0, 0, 1'b0);
      mism = 0;
      for (int c = 1; c <= 1010; c++) if (trace[c] !== golden[c]) mism++;
      chk("replay_trace", mism, 0);
      chk("replay_done_cnt", done_cnt, 1);

      // Restart: second edge 500 cycles in; en drop mid-window is ignored
      do_reset();
      clean = 1'b1;
      watch(1510, 500, 200, 1'b0);
      chk("restart_done_at", first_done, 1501);
      chk("restart_done_cnt", done_cnt, 1);
      chk("restart_busy_len", busy_cycles, 1500);
      chk("restart_settled", noisy, 1'b0);
      chk("restart_cnt", bounce_cnt, toggles);
      chk("restart_gap_range", gap_bad, 0);
      chk("restart_gap_lfsr", pred_bad, 0);

      // Back in IDLE with en=0: pass-through again
      clean = 1'b1;
      @(negedge clk);
      chk("idle_en0_pass", {noisy, busy}, 2'b10);
      clean = 1'b0;
      @(negedge clk);
      chk("idle_en0_fall", noisy, 1'b0);

      // Back-to-back: edge on the DONE cycle
      en    = 1'b1;
      clean = 1'b1;
      watch(2010, 0, 0, 1'b1);
      chk("b2b_first_done", first_done, 1001);
      chk("b2b_busy_again", busy_after_flip, 1'b1);
      chk("b2b_done_cnt", done_cnt, 2);
      chk("b2b_second_done", last_done, 2002);
      chk("b2b_busy_len", busy_cycles, 2000);
      chk("b2b_settled", noisy, 1'b0);
      chk("b2b_cnt", bounce_cnt, toggles);
      chk("b2b_gap_lfsr", pred_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bounce_generator.md
BOUNCE_GENERATOR -- requirements
Module: bounce_generator

Interface
REQ-001 The block SHALL provide parameter BOUNCE_CYCLES, default 1000, giving the bounce window length in clk cycles (minimum 2).
REQ-002 The block SHALL provide parameter GAP_W, default 4, giving the toggle-gap field width; each gap is 1..2^GAP_W cycles (minimum 1, maximum 16).
REQ-003 The block SHALL provide parameter SEED, default 16'hACE1, giving the LFSR reset value; it must be nonzero.
REQ-004 clk  input  1  sole clock, rising-edge active.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clean  input  1  ideal switch level, synchronous to clk.
REQ-007 en  input  1  1 = emulate contact bounce; 0 = pass-through.
REQ-008 noisy  output  1  emulated bouncing switch signal.
REQ-009 busy  output  1  high while in the BOUNCE state.
REQ-010 done  output  1  one-cycle pulse when noisy has settled to clean.
REQ-011 bounce_cnt  output  8  number of toggles in the current or last window.

Function
REQ-012 The block SHALL register clean into clean_q every cycle; an edge is defined as clean != clean_q.
REQ-013 The block SHALL run a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) that advances every cycle, including in IDLE.
REQ-014 The block SHALL implement three states: IDLE, BOUNCE and DONE.
REQ-015 In IDLE with en=0, noisy SHALL equal clean_q, giving 1-cycle latency from clean; busy and done stay 0.
REQ-016 In IDLE with en=1, an edge SHALL cause the following on the next clk edge:
  - state becomes BOUNCE, busy=1
  - noisy toggles
  - bounce_cnt loads 1
  - window counter loads BOUNCE_CYCLES-1
  - gap counter loads lfsr[GAP_W-1:0]
REQ-017 In BOUNCE, when the gap counter is 0, the block SHALL toggle noisy, increment bounce_cnt (saturating at 255) and reload gap from lfsr[GAP_W-1:0]; otherwise the gap counter decrements.
REQ-018 In BOUNCE, the window counter SHALL decrement every cycle.
REQ-019 When the window counter is 0, the block SHALL enter DONE on the next edge, with noisy=clean_q forced and busy=0.
REQ-020 The DONE state SHALL last exactly one cycle with done=1, then return to IDLE; bounce_cnt holds its value until the next BOUNCE entry.
REQ-021 An edge while in BOUNCE SHALL reload the window counter to BOUNCE_CYCLES-1 without clearing bounce_cnt; toggling continues.
REQ-022 An edge while in DONE SHALL be accepted: the state goes directly to BOUNCE per REQ-016 and done still pulses for that cycle.
REQ-023 The final settled noisy level SHALL always equal the clean level at the time of the last edge.
REQ-024 A change of en while in BOUNCE SHALL be ignored until the block returns to IDLE.
REQ-025 Toggle sequences SHALL be fully deterministic: for a given SEED and the same stimulus cycle timing, the toggle sequence is identical.

Reset
REQ-026 While reset=1, the block SHALL immediately force: noisy=0, busy=0, done=0, bounce_cnt=0, clean_q=0, state=IDLE, lfsr=SEED, and both counters to 0.
REQ-027 Reset asserted mid-BOUNCE SHALL abort the window with no done pulse; after release, the block resumes in IDLE.

Verification (BOUNCE_CYCLES=1000, GAP_W=4, SEED=16'hACE1)
REQ-028 Reset pulse: assert reset for 3 cycles -> all outputs are 0 during and after release while clean=0.
REQ-029 Pass-through: en=0, clean 0->1 -> noisy=1 exactly 1 cycle later; busy, done and bounce_cnt remain 0.
REQ-030 Single bounce: en=1, clean 0->1 -> the checks are:
  - busy=1 on the next cycle
  - every toggle gap is within 1..16 cycles
  - busy stays high for 1000 cycles
  - noisy=1 in the settled state
  - a single done pulse occurs
  - bounce_cnt equals the toggle count measured by the bench
REQ-031 Restart: clean 0->1, then 1->0 500 cycles later -> done pulses 1001 cycles after the second edge, the final noisy=0, and bounce_cnt is cumulative.
REQ-032 Reset mid-bounce: assert reset 300 cycles into the window -> outputs clear at once and no done pulse occurs; repeating the single-bounce scenario from reset then reproduces a bit-identical noisy trace.
REQ-033 Back-to-back: an edge on the DONE cycle -> the done pulse occurs, busy reasserts on the next cycle, and a new window completes correctly.
